alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
// - Shares one instance of the 32-bit combinational alu between NUM_REQ requesters.
// - Each requester presents (op1, op2, alu_op) over a valid/ready handshake.
// - Grants one request at a time in round-robin order, registers operands, computes,
//   and returns result + zero flag + requester id over a valid/ready response channel.
// - Sits between multi-cycle execution units (e.g. address-gen, iterative mul/div seq) and the ALU.
// PARAMETERS
// - NUM_REQ  2   number of requesters (2..8)
// - ID_W     1   width of rsp_id; must equal max(1,$clog2(NUM_REQ))
// PORTS
// - clk        in   1            system clock, all state updates on rising edge
// - rst_n      in   1            asynchronous reset, active-low
// - req_valid  in   NUM_REQ      bit i: requester i has an operation pending
// - req_ready  out  NUM_REQ      bit i: requester i's operation accepted this cycle (one-hot or zero)
// - req_op1    in   NUM_REQ*32   requester i operand1 at [32*i +: 32]
// - req_op2    in   NUM_REQ*32   requester i operand2 at [32*i +: 32]
// - req_alu_op in   NUM_REQ*4    requester i ALU opcode at [4*i +: 4], ALUOP_* encoding
// - rsp_valid  out  1            result available
// - rsp_ready  in   1            consumer accepts result
// - rsp_id     out  ID_W         index of requester that issued the result
// - rsp_result out  32           ALU result
// - rsp_zero   out  1            ALU zero flag for rsp_result
// - busy       out  1            high whenever state != IDLE
// BEHAVIOUR
// - Reset (async assert, sync-to-clk release): state=IDLE; rsp_valid=0, rsp_id=0, rsp_result=0,
//   rsp_zero=0, req_ready=0, busy=0; operand regs=0; rr pointer last=NUM_REQ-1 (req 0 wins first).
// - FSM states IDLE, EXEC, RESP:
//   IDLE: if any req_valid, grant = first set bit searching from last+1 upward, wrapping.
//         req_ready[grant]=1 combinationally this cycle; capture op1/op2/alu_op/id; last<=grant; ->EXEC.
//         If no req_valid stay IDLE, req_ready=0.
//   EXEC: captured operands drive alu; result and zero registered into rsp_*; ->RESP.
//   RESP: rsp_valid=1; rsp_* held stable until rsp_ready. On rsp_valid&rsp_ready ->IDLE.
// - req_ready only ever asserted in IDLE, never to a requester with req_valid=0.
// - Latency: accept edge -> rsp_valid high two edges later; min 3 cycles per op (no overlap).
// - Requester must hold req_* stable while req_valid=1 and req_ready=0; dropping req_valid
//   before grant is legal (request withdrawn, no response).
// - Round robin: after granting i, i has lowest priority next arbitration; no starvation:
//   any continuously-valid requester is granted within NUM_REQ grants.
// - Arithmetic: exactly the alu semantics; undefined alu_op codes yield op1+op2 (alu default).
//   SRA/SRL/SLL use op2[4:0] only. LESS is signed compare, result 0/1.
// - rsp_zero = (rsp_result == 0), registered with result, never recomputed in RESP.
// - Reset mid-operation (EXEC or RESP): op dropped, no response; outputs return to reset values.
// - rsp_ready high while rsp_valid low: ignored.
// STRUCTURE
// - Package alu_arbiter_pkg: typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t.
// - ALUOP_* constants come from riscv_alu_constants.sv; no local copies.
// - One sub-module: existing alu instantiated once (u_alu). Arbiter logic (rr search) inline as
//   a function; no separate arbiter module.
// TESTING
// - Single op: req0 ADD 5,7 -> req_ready[0] 1 cycle, rsp_valid 2 edges later, rsp_result=12, id=0, zero=0.
// - Contention: req0 and req1 valid every cycle, rsp_ready=1 -> ids 0,1,0,1; each op every 3 cycles.
// - Backpressure: rsp_ready=0 for 5 cycles on SUB 9,9 -> result=0, zero=1 held stable; req_ready
//   stays 0 for waiting requester until rsp accepted.
// - SRA 0x80000000 by op2=0x24 -> result 0xF8000000 (shift 4); LESS -1,1 -> 1.
// - Reset in RESP: rst_n low 1 cycle -> rsp_valid=0 immediately, busy=0, next grant goes to req 0.
// - Withdrawal: req1 valid 1 cycle while busy then dropped -> no grant, no rsp with id=1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types and widths for the ALU arbiter.
package alu_arbiter_pkg;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/riscv_alu_constants.sv
// ALU opcode encoding shared by the ALU and every unit that issues operations to it.
package riscv_alu_constants;
    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_AND  = 4'd2;
    localparam logic [3:0] ALUOP_OR   = 4'd3;
    localparam logic [3:0] ALUOP_XOR  = 4'd4;
    localparam logic [3:0] ALUOP_SLL  = 4'd5;
    localparam logic [3:0] ALUOP_SRL  = 4'd6;
    localparam logic [3:0] ALUOP_SRA  = 4'd7;
    localparam logic [3:0] ALUOP_LESS = 4'd8;
endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; unknown opcodes fall back to addition.
module alu
    import riscv_alu_constants::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [3:0]  alu_op,
    output logic [31:0] result,
    output logic        zero
);
    logic signed [31:0] sop1;
    logic signed [31:0] sop2;
    logic        [4:0]  shamt;

    assign sop1  = op1;
    assign sop2  = op2;
    assign shamt = op2[4:0];

    always_comb begin
        result = op1 + op2;
        case (alu_op)
            ALUOP_ADD:  result = op1 + op2;
            ALUOP_SUB:  result = op1 - op2;
            ALUOP_AND:  result = op1 & op2;
            ALUOP_OR:   result = op1 | op2;
            ALUOP_XOR:  result = op1 ^ op2;
            ALUOP_SLL:  result = op1 << shamt;
            ALUOP_SRL:  result = op1 >> shamt;
            ALUOP_SRA:  result = sop1 >>> shamt;
            ALUOP_LESS: result = {31'd0, sop1 < sop2};
            default:    result = op1 + op2;
        endcase
    end

    assign zero = (result == 32'd0);
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters, one operation in flight.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_op1,
    input  logic [NUM_REQ*DATA_W-1:0]   req_op2,
    input  logic [NUM_REQ*OP_W-1:0]     req_alu_op,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [DATA_W-1:0]           rsp_result,
    output logic                        rsp_zero,
    output logic                        busy
);
    arb_state_t          state;
    logic [ID_W-1:0]     last;
    logic [ID_W-1:0]     grant;
    logic [DATA_W-1:0]   sel_op1;
    logic [DATA_W-1:0]   sel_op2;
    logic [OP_W-1:0]     sel_aluop;

    logic [DATA_W-1:0]   op1_p0;
    logic [DATA_W-1:0]   op2_p0;
    logic [OP_W-1:0]     aluop_p0;
    logic [ID_W-1:0]     id_p0;

    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;

    // Distance from last+1 (mod NUM_REQ) ranks each requester; the nearest valid one wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [ID_W-1:0]    prev);
        logic [ID_W-1:0] pick;
        int              best_d;
        int              d;
        pick   = '0;
        best_d = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            d = (j + 2 * NUM_REQ - int'(prev) - 1) % NUM_REQ;
            if (vld[j] && d < best_d) begin
                best_d = d;
                pick   = ID_W'(j);
            end
        end
        return pick;
    endfunction

    assign grant = rr_pick(req_valid, last);
    assign busy  = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (state == IDLE && rst_n && (|req_valid)) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        sel_op1   = '0;
        sel_op2   = '0;
        sel_aluop = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (ID_W'(j) == grant) begin
                sel_op1   = req_op1[DATA_W*j +: DATA_W];
                sel_op2   = req_op2[DATA_W*j +: DATA_W];
                sel_aluop = req_alu_op[OP_W*j +: OP_W];
            end
        end
    end

    alu u_alu (
        .op1    (op1_p0),
        .op2    (op2_p0),
        .alu_op (aluop_p0),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= ID_W'(NUM_REQ - 1);
            op1_p0     <= '0;
            op2_p0     <= '0;
            aluop_p0   <= '0;
            id_p0      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                // p0: capture the granted request
                IDLE: begin
                    if (|req_valid) begin
                        op1_p0   <= sel_op1;
                        op2_p0   <= sel_op2;
                        aluop_p0 <= sel_aluop;
                        id_p0    <= grant;
                        last     <= grant;
                        state    <= EXEC;
                    end
                end
                // p1: register ALU output; zero flag is frozen here with the result
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_id     <= id_p0;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed stimulus pushes hand-computed responses, a monitor checks them.
module tb_alu_arbiter;
    import riscv_alu_constants::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*32-1:0]  req_op1;
    logic [NUM_REQ*32-1:0]  req_op2;
    logic [NUM_REQ*4-1:0]   req_alu_op;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [31:0]            rsp_result;
    logic                   rsp_zero;
    logic                   busy;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_grant_cyc = -1;
    logic            have_prev = 1'b0;
    logic [ID_W-1:0] prev_id;
    logic [31:0]     prev_res;
    logic            prev_zero;

    alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_alu_op (req_alu_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void checkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endfunction

    // Monitor: request-side protocol checks and response scoreboard
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            have_prev      = 1'b0;
            last_grant_cyc = -1;
        end else begin
            if (req_ready != '0) begin
                checkb("grant_onehot", $onehot(req_ready), 1'b1);
                checkb("grant_to_valid", (req_ready & ~req_valid) == '0, 1'b1);
                checkb("grant_only_idle", busy, 1'b0);
                if (last_grant_cyc >= 0)
                    checkb("grant_spacing", (cyc - last_grant_cyc) >= 3, 1'b1);
                last_grant_cyc = cyc;
            end
            if (rsp_valid) begin
                if (have_prev) begin
                    check("rsp_hold_result", rsp_result, prev_res);
                    checkb("rsp_hold_zero", rsp_zero, prev_zero);
                    check("rsp_hold_id", 32'(rsp_id), 32'(prev_id));
                end
                if (rsp_ready) begin
                    have_prev = 1'b0;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got id=%0d result=0x%08h, required no response",
                                 rsp_id, rsp_result);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", 32'(rsp_id), e.id);
                        check("rsp_result", rsp_result, e.res);
                        checkb("rsp_zero", rsp_zero, e.zero);
                    end
                end else begin
                    have_prev = 1'b1;
                    prev_id   = rsp_id;
                    prev_res  = rsp_result;
                    prev_zero = rsp_zero;
                end
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    task automatic expect_rsp(input int id, input logic [31:0] res);
        exp_t e;
        e.id   = id;
        e.res  = res;
        e.zero = (res == 32'd0);
        sb.push_back(e);
    endtask

    task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_op1[32*i +: 32]  = a;
        req_op2[32*i +: 32]  = b;
        req_alu_op[4*i +: 4] = op;
        req_valid[i]         = 1'b1;
    endtask

    // Returns just after the edge that accepted requester i.
    task automatic wait_accept(input int i);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout_req%0d: got no req_ready in 40 cycles, required a grant", i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=%b rsp_valid=%b after 40 cycles, required idle", busy, rsp_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic single(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] res);
        expect_rsp(i, res);
        drive(i, a, b, op);
        wait_accept(i);
        req_valid[i] = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = '1;
        req_op1    = '0;
        req_op2    = '0;
        req_alu_op = '0;
        rsp_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        checkb("reset_rsp_valid", rsp_valid, 1'b0);
        checkb("reset_busy", busy, 1'b0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        checkb("reset_rsp_zero", rsp_zero, 1'b0);
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;

        // Single op with latency checks
        expect_rsp(0, 32'd12);
        drive(0, 32'd5, 32'd7, ALUOP_ADD);
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkb("lat_exec_valid", rsp_valid, 1'b0);
        checkb("lat_exec_busy", busy, 1'b1);
        @(negedge clk);
        checkb("lat_resp_valid", rsp_valid, 1'b1);
        wait_idle();

        // Leave last=1 so contention starts at requester 0
        single(1, 32'h0000000F, 32'h000000F0, ALUOP_OR, 32'h000000FF);

        // Contention: expected ids 0,1,0,1
        expect_rsp(0, 32'd3);
        expect_rsp(1, 32'd7);
        expect_rsp(0, 32'hF00FF00F);
        expect_rsp(1, 32'h0000F000);
        fork
            begin
                drive(0, 32'd1, 32'd2, ALUOP_ADD);
                wait_accept(0);
                drive(0, 32'hFF00FF00, 32'h0F0F0F0F, ALUOP_XOR);
                wait_accept(0);
                req_valid[0] = 1'b0;
            end
            begin
                drive(1, 32'd10, 32'd3, ALUOP_SUB);
                wait_accept(1);
                drive(1, 32'h0000F0F0, 32'h0000FF00, ALUOP_AND);
                wait_accept(1);
                req_valid[1] = 1'b0;
            end
        join
        wait_idle();

        // Backpressure: SUB 9,9 held while requester 1 waits
        rsp_ready = 1'b0;
        expect_rsp(0, 32'd0);
        expect_rsp(1, 32'd5);
        drive(0, 32'd9, 32'd9, ALUOP_SUB);
        drive(1, 32'd2, 32'd3, ALUOP_ADD);
        wait_accept(0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkb("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_result", rsp_result, 32'd0);
            checkb("bp_rsp_zero", rsp_zero, 1'b1);
            check("bp_waiting_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_accept(1);
        req_valid[1] = 1'b0;
        wait_idle();

        // Shifts, signed compare, undefined opcode, wrap to zero
        single(0, 32'hFFFFFFFF, 32'd1, ALUOP_LESS, 32'd1);
        single(1, 32'h80000000, 32'h00000024, ALUOP_SRA, 32'hF8000000);
        single(0, 32'h80000000, 32'h00000004, ALUOP_SRL, 32'h08000000);
        single(1, 32'h00000001, 32'h0000003F, ALUOP_SLL, 32'h80000000);
        single(0, 32'd3, 32'd4, 4'hF, 32'd7);
        single(1, 32'hFFFFFFFF, 32'd1, ALUOP_ADD, 32'd0);
        single(0, 32'd1, 32'hFFFFFFFF, ALUOP_LESS, 32'd0);

        // Reset while in RESP: op dropped, arbitration restarts at requester 0
        rsp_ready = 1'b0;
        drive(0, 32'd1, 32'd1, ALUOP_ADD);
        wait_accept(0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkb("pre_rst_rsp_valid", rsp_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkb("rst_mid_rsp_valid", rsp_valid, 1'b0);
        checkb("rst_mid_busy", busy, 1'b0);
        check("rst_mid_rsp_result", rsp_result, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        expect_rsp(0, 32'd100);
        expect_rsp(1, 32'd200);
        drive(0, 32'd60, 32'd40, ALUOP_ADD);
        drive(1, 32'd250, 32'd50, ALUOP_SUB);
        @(negedge clk);
        check("post_rst_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_accept(1);
        req_valid[1] = 1'b0;
        wait_idle();

        // Withdrawal: requester 1 valid for one busy cycle, then dropped
        rsp_ready = 1'b0;
        expect_rsp(0, 32'h00000055);
        drive(0, 32'h0000005A, 32'h0000000F, ALUOP_XOR);
        wait_accept(0);
        req_valid[0] = 1'b0;
        drive(1, 32'd7, 32'd7, ALUOP_SUB);
        @(negedge clk);
        check("wd_busy_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle();
        repeat (6) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        checkb("final_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
